// File: rtl/conv_pkg.sv
// Shared types and widths for the 1-D convolution datapath: feeder FSM state
// encoding, operand and accumulator widths, and a width helper for counters.
package conv_pkg;

  localparam int OPERAND_W = 14;
  localparam int ACC_W     = 2 * OPERAND_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_W,
    ISSUE,
    DRAIN,
    CLEAR,
    DONE
  } feeder_state_t;

  // Bits needed to count 0..value-1, never less than one bit so that
  // degenerate bounds (a single output, a single tap) still give a legal vector.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/operand_store.sv
// Operand storage for the feeder: x vector (N x T) and kernel w (M x T).
// One shared write-data port and combinational reads at (n+k) and (k).
module operand_store
  import conv_pkg::*;
#(
  parameter int T   = OPERAND_W,
  parameter int N   = 16,
  parameter int M   = 4,
  parameter int XAW = clog2_min1(N),
  parameter int WAW = clog2_min1(M)
) (
  input  logic           clk,
  input  logic           i_x_we,
  input  logic           i_w_we,
  input  logic [XAW-1:0] i_x_waddr,
  input  logic [WAW-1:0] i_w_waddr,
  input  logic [T-1:0]   i_wdata,
  input  logic [XAW-1:0] i_x_raddr,
  input  logic [WAW-1:0] i_w_raddr,
  output logic [T-1:0]   o_x,
  output logic [T-1:0]   o_w
);

  logic [T-1:0] r_x_mem [N];
  logic [T-1:0] r_w_mem [M];

  // Capture stream words into the addressed x or w entry.
  // NOTE: the arrays have no reset; every entry is rewritten by the load
  // phase before it is read, so resetting them would only add cost.
  always_ff @(posedge clk) begin
    if (i_x_we) r_x_mem[i_x_waddr] <= i_wdata;
    if (i_w_we) r_w_mem[i_w_waddr] <= i_wdata;
  end

  assign o_x = r_x_mem[i_x_raddr];
  // The first kernel read happens on the same edge as the last tap write
  // (visible when M=1), so a matching write is forwarded to the read port.
  assign o_w = (i_w_we && (i_w_waddr == i_w_raddr)) ? i_wdata : r_w_mem[i_w_raddr];

endmodule

// File: rtl/conv1d_mac_feeder.sv
// Operand sequencer for a pipelined MAC computing a valid-mode 1-D convolution.
// Loads x then w from a valid/ready stream, issues the (x[n+k], w[k]) pairs for
// each output n, waits out the MAC latency, strobes the finished y[n], and
// clears the accumulator before the next output. All outputs are registered.
module conv1d_mac_feeder
  import conv_pkg::*;
#(
  parameter int T       = OPERAND_W,
  parameter int N       = 16,
  parameter int M       = 4,
  parameter int MAC_LAT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [T-1:0]                 s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [T-1:0]                 mac_a,
  output logic [T-1:0]                 mac_b,
  output logic                         mac_valid,
  output logic                         mac_clear,
  output logic                         y_strobe,
  output logic [clog2_min1(N-M+1)-1:0] y_index,
  output logic                         done
);

  localparam int XAW = clog2_min1(N);
  localparam int WAW = clog2_min1(M);
  localparam int NW  = clog2_min1(N - M + 1);
  localparam int DW  = clog2_min1(MAC_LAT);

  localparam logic [XAW-1:0] X_LAST = XAW'(N - 1);
  localparam logic [XAW-1:0] W_LAST = XAW'(M - 1);
  localparam logic [NW-1:0]  N_LAST = NW'(N - M);
  localparam logic [WAW-1:0] K_LAST = WAW'(M - 1);
  localparam logic [DW-1:0]  D_LAST = DW'(MAC_LAT - 1);

  feeder_state_t  r_state, w_state_next;
  logic [XAW-1:0] r_cnt,   w_cnt_next;
  logic [NW-1:0]  r_n,     w_n_next;
  logic [WAW-1:0] r_k,     w_k_next;
  logic [DW-1:0]  r_drain, w_drain_next;

  logic           w_xfer, w_x_we, w_w_we;
  logic [XAW-1:0] w_x_raddr;
  logic [T-1:0]   w_x_rd, w_w_rd;

  logic           w_s_ready_d, w_mac_valid_d, w_mac_clear_d, w_y_strobe_d, w_done_d;
  logic [T-1:0]   w_mac_a_d, w_mac_b_d;
  logic [NW-1:0]  w_y_index_d;

  // s_ready is the registered image of "state is LOAD_*", so it also gates writes.
  assign w_xfer = s_valid && s_ready;
  assign w_x_we = w_xfer && (r_state == LOAD_X);
  assign w_w_we = w_xfer && (r_state == LOAD_W);

  // Operands for the next cycle are read at the next (n, k).
  assign w_x_raddr = XAW'(w_n_next) + XAW'(w_k_next);

  operand_store #(
    .T   (T),
    .N   (N),
    .M   (M),
    .XAW (XAW),
    .WAW (WAW)
  ) u_store (
    .clk       (clk),
    .i_x_we    (w_x_we),
    .i_w_we    (w_w_we),
    .i_x_waddr (r_cnt),
    .i_w_waddr (r_cnt[WAW-1:0]),
    .i_wdata   (s_data),
    .i_x_raddr (w_x_raddr),
    .i_w_raddr (w_k_next),
    .o_x       (w_x_rd),
    .o_w       (w_w_rd)
  );

  // State and counter register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_n     <= w_n_next;
      r_k     <= w_k_next;
      r_drain <= w_drain_next;
    end
  end

  // Next-state and counter sequencing.
  // NOTE: every target gets a default first, so no path can leave a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_n_next     = r_n;
    w_k_next     = r_k;
    w_drain_next = r_drain;
    unique case (r_state)
      IDLE: begin
        w_state_next = LOAD_X;
        w_cnt_next   = '0;
      end
      LOAD_X: if (w_xfer) begin
        if (r_cnt == X_LAST) begin
          w_state_next = LOAD_W;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + XAW'(1);
        end
      end
      LOAD_W: if (w_xfer) begin
        if (r_cnt == W_LAST) begin
          w_state_next = ISSUE;
          w_n_next     = '0;
          w_k_next     = '0;
        end else begin
          w_cnt_next = r_cnt + XAW'(1);
        end
      end
      ISSUE: begin
        if (r_k == K_LAST) begin
          w_state_next = DRAIN;
          w_drain_next = '0;
        end else begin
          w_k_next = r_k + WAW'(1);
        end
      end
      DRAIN: begin
        if (r_drain == D_LAST) w_state_next = CLEAR;
        else                   w_drain_next = r_drain + DW'(1);
      end
      CLEAR: begin
        if (r_n == N_LAST) begin
          w_state_next = DONE;
        end else begin
          w_state_next = ISSUE;
          w_n_next     = r_n + NW'(1);
          w_k_next     = '0;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the next state, so registered outputs line up with it.
  always_comb begin
    w_s_ready_d   = (w_state_next == LOAD_X) || (w_state_next == LOAD_W);
    w_mac_valid_d = (w_state_next == ISSUE);
    w_mac_clear_d = (w_state_next == CLEAR);
    w_y_strobe_d  = (w_state_next == DRAIN) && (w_drain_next == D_LAST);
    w_done_d      = (w_state_next == DONE);
    w_mac_a_d     = mac_a;
    w_mac_b_d     = mac_b;
    w_y_index_d   = y_index;
    if (w_mac_valid_d) begin
      w_mac_a_d = w_x_rd;
      w_mac_b_d = w_w_rd;
    end
    if (w_y_strobe_d) w_y_index_d = w_n_next;
  end

  // Output register; reset holds the MAC in clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_valid <= 1'b0;
      mac_clear <= 1'b1;
      y_strobe  <= 1'b0;
      y_index   <= '0;
      done      <= 1'b0;
    end else begin
      s_ready   <= w_s_ready_d;
      mac_a     <= w_mac_a_d;
      mac_b     <= w_mac_b_d;
      mac_valid <= w_mac_valid_d;
      mac_clear <= w_mac_clear_d;
      y_strobe  <= w_y_strobe_d;
      y_index   <= w_y_index_d;
      done      <= w_done_d;
    end
  end

endmodule

// File: tb/tb_conv1d_mac_feeder.sv
// Bench: two feeders (N=8/M=3 and N=4/M=4), each driving a behavioural
// 3-cycle MAC. Expected y values are queued when a load is driven and popped
// whenever the feeder strobes a finished result.
module tb_conv1d_mac_feeder;

  localparam int AN  = 8;
  localparam int AM  = 3;
  localparam int BN  = 4;
  localparam int BM  = 4;
  localparam int LAT = 3;

  typedef struct {
    int                 idx;
    logic signed [27:0] y;
  } exp_t;

  typedef struct {
    logic               s_ready, mac_valid, mac_clear, y_strobe, done;
    logic [13:0]        mac_a, mac_b;
    logic [2:0]         y_index;
    logic signed [27:0] f;
  } obs_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic [13:0] a_s_data = '0, b_s_data = '0;
  logic        a_s_valid = 1'b0, b_s_valid = 1'b0;
  logic        a_s_ready, a_mac_valid, a_mac_clear, a_y_strobe, a_done;
  logic        b_s_ready, b_mac_valid, b_mac_clear, b_y_strobe, b_done;
  logic [13:0] a_mac_a, a_mac_b, b_mac_a, b_mac_b;
  logic [2:0]  a_y_index;
  logic [0:0]  b_y_index;

  conv1d_mac_feeder #(.T(14), .N(AN), .M(AM), .MAC_LAT(LAT)) u_dut_a (
    .clk(clk), .reset(rst_a), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .mac_a(a_mac_a), .mac_b(a_mac_b), .mac_valid(a_mac_valid), .mac_clear(a_mac_clear),
    .y_strobe(a_y_strobe), .y_index(a_y_index), .done(a_done)
  );

  conv1d_mac_feeder #(.T(14), .N(BN), .M(BM), .MAC_LAT(LAT)) u_dut_b (
    .clk(clk), .reset(rst_b), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .mac_a(b_mac_a), .mac_b(b_mac_b), .mac_valid(b_mac_valid), .mac_clear(b_mac_clear),
    .y_strobe(b_y_strobe), .y_index(b_y_index), .done(b_done)
  );

  // MAC model: input register, product register, accumulator (3-cycle latency).
  logic signed [13:0] a_ra, a_rb, b_ra, b_rb;
  logic signed [27:0] a_p, a_f, b_p, b_f;
  logic               a_rv, a_pv, b_rv, b_pv;

  always_ff @(posedge clk or posedge a_mac_clear) begin
    if (a_mac_clear) begin
      a_ra <= '0; a_rb <= '0; a_rv <= 1'b0; a_p <= '0; a_pv <= 1'b0; a_f <= '0;
    end else begin
      a_ra <= a_mac_a; a_rb <= a_mac_b; a_rv <= a_mac_valid;
      a_p  <= a_ra * a_rb; a_pv <= a_rv;
      if (a_pv) a_f <= a_f + a_p;
    end
  end

  always_ff @(posedge clk or posedge b_mac_clear) begin
    if (b_mac_clear) begin
      b_ra <= '0; b_rb <= '0; b_rv <= 1'b0; b_p <= '0; b_pv <= 1'b0; b_f <= '0;
    end else begin
      b_ra <= b_mac_a; b_rb <= b_mac_b; b_rv <= b_mac_valid;
      b_p  <= b_ra * b_rb; b_pv <= b_rv;
      if (b_pv) b_f <= b_f + b_p;
    end
  end

  function automatic obs_t observe(input int inst);
    obs_t o;
    if (inst == 0) begin
      o.s_ready = a_s_ready; o.mac_valid = a_mac_valid; o.mac_clear = a_mac_clear;
      o.y_strobe = a_y_strobe; o.done = a_done; o.mac_a = a_mac_a; o.mac_b = a_mac_b;
      o.y_index = a_y_index; o.f = a_f;
    end else begin
      o.s_ready = b_s_ready; o.mac_valid = b_mac_valid; o.mac_clear = b_mac_clear;
      o.y_strobe = b_y_strobe; o.done = b_done; o.mac_a = b_mac_a; o.mac_b = b_mac_b;
      o.y_index = {2'b00, b_y_index}; o.f = b_f;
    end
    return o;
  endfunction

  task automatic drive(input int inst, input logic [13:0] d, input logic v);
    if (inst == 0) begin a_s_data = d; a_s_valid = v; end
    else           begin b_s_data = d; b_s_valid = v; end
  endtask

  // Streams x then w; queues the expected y[n]. Returns at the negedge after
  // the final transfer (first ISSUE cycle).
  task automatic load_vec(input int inst, input string name, input int nx, input int nw,
                          input int xs[16], input int ws[4], input bit gappy);
    logic [13:0] words[$];
    exp_t        e;
    int          idx, cyc, y;
    bit          v, acc;
    obs_t        o;
    for (int i = 0; i < nx; i++) words.push_back(14'(xs[i]));
    for (int i = 0; i < nw; i++) words.push_back(14'(ws[i]));
    for (int n = 0; n <= nx - nw; n++) begin
      y = 0;
      for (int k = 0; k < nw; k++) y += xs[n + k] * ws[k];
      e.idx = n;
      e.y   = 28'(y);
      sb_q.push_back(e);
    end
    idx = 0;
    cyc = 0;
    while (idx < words.size() && cyc < 400) begin
      v = gappy ? ((cyc % 2) == 0) : 1'b1;
      drive(inst, v ? words[idx] : 14'h2AAA, v);
      o   = observe(inst);
      acc = v && o.s_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    checks++;
    if (idx != words.size()) begin
      failures++;
      $display("FAIL %s load_transfers got=%0d expected=%0d", name, idx, words.size());
    end
  endtask

  // Drains the scoreboard while the compute phase runs, holding s_valid high
  // with junk so any acceptance outside the load phase is caught.
  task automatic collect(input int inst, input string name, input int period, input int first_lat);
    obs_t        o;
    exp_t        e;
    int          cyc, last_strobe, ready_err, hold_err, gap, want_gap;
    bit          have_last, finished;
    logic [13:0] last_a, last_b;
    cyc = 0; last_strobe = -1; ready_err = 0; hold_err = 0;
    have_last = 1'b0; finished = 1'b0; last_a = '0; last_b = '0;
    while (!finished && cyc < 300) begin
      drive(inst, 14'h1555, 1'b1);
      @(negedge clk);
      cyc++;
      o = observe(inst);
      if (o.s_ready) ready_err++;
      if (o.mac_valid) begin
        last_a = o.mac_a; last_b = o.mac_b; have_last = 1'b1;
      end else if (have_last && (o.mac_a !== last_a || o.mac_b !== last_b)) begin
        hold_err++;
      end
      if (o.y_strobe) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_strobe cycle=%0d index=%0d f=%0d", name, cyc, o.y_index, o.f);
        end else begin
          e = sb_q.pop_front();
          if (o.f !== e.y) begin
            failures++;
            $display("FAIL %s y_value n=%0d got=%0d expected=%0d", name, e.idx, o.f, e.y);
          end
          checks++;
          if (o.y_index !== 3'(e.idx)) begin
            failures++;
            $display("FAIL %s y_index got=%0d expected=%0d", name, o.y_index, e.idx);
          end
          gap      = (last_strobe < 0) ? cyc : cyc - last_strobe;
          want_gap = (last_strobe < 0) ? first_lat : period;
          checks++;
          if (gap != want_gap) begin
            failures++;
            $display("FAIL %s strobe_spacing n=%0d got=%0d expected=%0d", name, e.idx, gap, want_gap);
          end
        end
        last_strobe = cyc;
      end
      if (o.done) begin
        finished = 1'b1;
        // DONE follows the CLEAR that comes after the final strobe.
        checks++;
        if (cyc - last_strobe != 2) begin
          failures++;
          $display("FAIL %s done_delay got=%0d expected=2", name, cyc - last_strobe);
        end
      end
    end
    drive(inst, '0, 1'b0);
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s done_timeout got=no_done expected=done within 300 cycles", name);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_strobes got=%0d_left expected=0", name, sb_q.size());
      sb_q.delete();
    end
    checks++;
    if (ready_err != 0) begin
      failures++;
      $display("FAIL %s s_ready_outside_load got=%0d_cycles expected=0", name, ready_err);
    end
    checks++;
    if (hold_err != 0) begin
      failures++;
      $display("FAIL %s operand_hold got=%0d_changes expected=0", name, hold_err);
    end
  endtask

  task automatic check_reset_vals(input int inst, input string name);
    obs_t o;
    o = observe(inst);
    checks++;
    if ({o.s_ready, o.mac_valid, o.mac_clear, o.y_strobe, o.done} !== 5'b00100 ||
        o.mac_a !== 14'd0 || o.mac_b !== 14'd0 || o.y_index !== 3'd0) begin
      failures++;
      $display("FAIL %s reset_values got ready=%b valid=%b clear=%b strobe=%b done=%b a=%h b=%h idx=%0d expected clear=1 rest=0",
               name, o.s_ready, o.mac_valid, o.mac_clear, o.y_strobe, o.done, o.mac_a, o.mac_b, o.y_index);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals(0, "reset_a");
    check_reset_vals(1, "reset_b");
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    o = observe(0);
    checks++;
    if (o.s_ready !== 1'b1 || o.mac_clear !== 1'b0) begin
      failures++;
      $display("FAIL leave_idle got ready=%b clear=%b expected ready=1 clear=0", o.s_ready, o.mac_clear);
    end
  endtask

  task automatic test_basic(input bit gappy);
    int xs[16];
    int ws[4];
    xs = '{default: 0};
    ws = '{default: 0};
    for (int i = 0; i < AN; i++) xs[i] = i + 1;
    for (int k = 0; k < AM; k++) ws[k] = 1;
    load_vec(0, gappy ? "gappy" : "basic", AN, AM, xs, ws, gappy);
    collect(0, gappy ? "gappy" : "basic", AM + LAT + 1, AM + LAT - 1);
  endtask

  task automatic test_min_operand();
    int xs[16];
    int ws[4];
    xs = '{default: 0};
    ws = '{default: 0};
    for (int i = 0; i < AN; i++) xs[i] = -8192;
    ws[0] = -8192;
    load_vec(0, "min_operand", AN, AM, xs, ws, 1'b0);
    collect(0, "min_operand", AM + LAT + 1, AM + LAT - 1);
  endtask

  task automatic test_reset_mid();
    int   xs[16];
    int   ws[4];
    obs_t o;
    exp_t e;
    int   cyc, group, run;
    bit   prev_valid, hit;
    xs = '{default: 0};
    ws = '{default: 0};
    for (int i = 0; i < AN; i++) xs[i] = i + 1;
    for (int k = 0; k < AM; k++) ws[k] = 1;
    load_vec(0, "reset_mid", AN, AM, xs, ws, 1'b0);
    cyc = 0; group = 0; run = 0; prev_valid = 1'b0; hit = 1'b0;
    while (!hit && cyc < 200) begin
      o = observe(0);
      if (o.mac_valid) begin
        if (!prev_valid) begin group++; run = 1; end
        else run++;
      end
      prev_valid = o.mac_valid;
      if (o.y_strobe && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (o.f !== e.y) begin
          failures++;
          $display("FAIL reset_mid y_value n=%0d got=%0d expected=%0d", e.idx, o.f, e.y);
        end
      end
      if (group == 3 && run == 2) begin
        hit = 1'b1;
        rst_a = 1'b1;
        #1;
        check_reset_vals(0, "reset_mid");
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!hit || sb_q.size() != 4) begin
      failures++;
      $display("FAIL reset_mid strobes_before_reset got_hit=%0d left=%0d expected hit=1 left=4", hit, sb_q.size());
    end
    sb_q.delete();
    @(negedge clk);
    rst_a = 1'b0;
    ws[0] = 1; ws[1] = 0; ws[2] = -1;
    load_vec(0, "reload", AN, AM, xs, ws, 1'b0);
    collect(0, "reload", AM + LAT + 1, AM + LAT - 1);
  endtask

  task automatic test_back_to_back();
    int xs[16];
    int ws[4];
    xs = '{default: 0};
    ws = '{default: 0};
    for (int i = 0; i < AN; i++) xs[i] = i + 1;
    ws[0] = 2;
    load_vec(0, "back_to_back", AN, AM, xs, ws, 1'b0);
    collect(0, "back_to_back", AM + LAT + 1, AM + LAT - 1);
  endtask

  task automatic test_single_output();
    int xs[16];
    int ws[4];
    xs = '{default: 0};
    ws = '{default: 0};
    xs[0] = 3;  xs[1] = -5; xs[2] = 7;  xs[3] = 100;
    ws[0] = 2;  ws[1] = 4;  ws[2] = -1; ws[3] = 1;
    load_vec(1, "single_output", BN, BM, xs, ws, 1'b0);
    collect(1, "single_output", BM + LAT + 1, BM + LAT - 1);
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_min_operand();
    test_reset_mid();
    test_back_to_back();
    test_single_output();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
